// File: rtl/ofm_buffer_pkg.sv
// Shared types and helpers for the multi-channel OFM buffer.
package ofm_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic RD_MODE_PAR   = 1'b0;
    localparam logic RD_MODE_CHMAJ = 1'b1;

    function automatic int calc_ofm_size(input int ifm, input int k, input int s, input int p);
        return (ifm - k + 2 * p) / s + 1;
    endfunction

endpackage

// File: rtl/ofm_buffer_ram.sv
// Simple dual-port RAM with a registered read port; contents are not reset.
module ofm_buffer_ram #(
    parameter int DEPTH  = 25,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Same-address read and write returns the old word (read-before-write).
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ofm_buffer_mc.sv
// Multi-channel OFM frame buffer: pixel-parallel FIFO or channel-major drain.
// Optional sticky error flag built when OFM_BUFFER_ERR_FLAG_EN is defined.
module ofm_buffer_mc
    import ofm_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CH      = 4,
    parameter int IFM_SIZE    = 9,
    parameter int KERNEL_SIZE = 4,
    parameter int STRIDE      = 2,
    parameter int PAD         = 2,
    localparam int OFM_SIZE   = calc_ofm_size(IFM_SIZE, KERNEL_SIZE, STRIDE, PAD),
    localparam int DEPTH      = OFM_SIZE * OFM_SIZE,
    localparam int ADDR_W     = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH + 1),
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int W          = NUM_CH * DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_mode_i,
    input  logic             wr_en_i,
    input  logic [W-1:0]     d_in_i,
    input  logic             rd_en_i,
    output logic [W-1:0]     d_out_o,
    output logic             rd_valid_o,
    output logic [CH_W-1:0]  rd_ch_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             frame_done_o,
    output logic             err_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    state_e            state_q, state_d;
    logic              mode_q;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CH_W-1:0]   rd_ch_q, out_ch_q;
    logic [CNT_W-1:0]  count_q, count_d, rd_cnt_q, rd_cnt_d;
    logic              full_q, empty_q, rd_valid_q, frame_done_q, out_chmaj_q;
    logic              wr_acc_s, rd_acc_s, chmaj_last_s, par_end_s, frame_end_s;
    logic [W-1:0]      ram_rd_data_s, d_out_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (wr_en_i) state_d = ST_FILL; else state_d = ST_IDLE;
            ST_FILL: begin
                if (frame_end_s)             state_d = ST_IDLE;
                else if (count_d == DEPTH_CNT) state_d = ST_READY;
                else                         state_d = ST_FILL;
            end
            ST_READY: begin
                if (frame_end_s)                             state_d = ST_IDLE;
                else if (mode_q == RD_MODE_CHMAJ && rd_en_i) state_d = ST_DRAIN;
                else                                         state_d = ST_READY;
            end
            ST_DRAIN: if (frame_end_s) state_d = ST_IDLE; else state_d = ST_DRAIN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Accept/drop decisions per state and latched mode
    always_comb begin
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        case (state_q)
            ST_IDLE: wr_acc_s = wr_en_i;
            ST_FILL, ST_READY: begin
                if (mode_q == RD_MODE_CHMAJ) begin
                    if (state_q == ST_FILL) wr_acc_s = wr_en_i && !full_q;
                    else                    rd_acc_s = rd_en_i;
                end else begin
                    rd_acc_s = rd_en_i && !empty_q;
                    wr_acc_s = wr_en_i && (!full_q || rd_acc_s);
                end
            end
            ST_DRAIN: rd_acc_s = rd_en_i;
            default: begin
                wr_acc_s = 1'b0;
                rd_acc_s = 1'b0;
            end
        endcase
    end

    // Occupancy and end-of-frame detection; channel-major reads never decrement
    always_comb begin
        chmaj_last_s = (mode_q == RD_MODE_CHMAJ) && rd_acc_s &&
                       (rd_ptr_q == LAST_ADDR) && (rd_ch_q == LAST_CH);
        if (chmaj_last_s) begin
            count_d = '0;
        end else if (wr_acc_s && !(rd_acc_s && mode_q == RD_MODE_PAR)) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc_s && !wr_acc_s && mode_q == RD_MODE_PAR) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
        if (rd_acc_s && mode_q == RD_MODE_PAR && rd_cnt_q != DEPTH_CNT) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
        par_end_s   = (mode_q == RD_MODE_PAR) && (state_q == ST_FILL || state_q == ST_READY) &&
                      (rd_cnt_d == DEPTH_CNT) && (count_d == '0);
        frame_end_s = chmaj_last_s || par_end_s;
    end

    // Pointers, counters, mode latch and registered status/output qualifiers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= RD_MODE_PAR;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_ch_q      <= '0;
            count_q      <= '0;
            rd_cnt_q     <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            rd_valid_q   <= 1'b0;
            out_chmaj_q  <= 1'b0;
            out_ch_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && wr_en_i) mode_q <= rd_mode_i;
            if (chmaj_last_s)  wr_ptr_q <= '0;
            else if (wr_acc_s) wr_ptr_q <= (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_W'(1);
            if (rd_acc_s)      rd_ptr_q <= (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_W'(1);
            if (chmaj_last_s) begin
                rd_ch_q <= '0;
            end else if (rd_acc_s && mode_q == RD_MODE_CHMAJ && rd_ptr_q == LAST_ADDR) begin
                rd_ch_q <= rd_ch_q + CH_W'(1);
            end
            count_q      <= count_d;
            rd_cnt_q     <= par_end_s ? '0 : rd_cnt_d;
            full_q       <= (count_d == DEPTH_CNT);
            empty_q      <= (count_d == '0);
            rd_valid_q   <= rd_acc_s;
            out_chmaj_q  <= mode_q;
            out_ch_q     <= (rd_acc_s && mode_q == RD_MODE_CHMAJ) ? rd_ch_q : '0;
            frame_done_q <= frame_end_s;
        end
    end

    ofm_buffer_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_acc_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (d_in_i),
        .rd_en_i   (rd_acc_s),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data_s)
    );

    // Output lane steering; zero whenever no read was accepted
    always_comb begin
        d_out_s = '0;
        if (!rd_valid_q) begin
            d_out_s = '0;
        end else if (out_chmaj_q == RD_MODE_CHMAJ) begin
            d_out_s[DATA_WIDTH-1:0] = ram_rd_data_s[out_ch_q * DATA_WIDTH +: DATA_WIDTH];
        end else begin
            d_out_s = ram_rd_data_s;
        end
    end

`ifdef OFM_BUFFER_ERR_FLAG_EN
    logic err_q;

    // Sticky flag for any dropped write or ignored read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((wr_en_i && !wr_acc_s) || (rd_en_i && !rd_acc_s)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign d_out_o      = d_out_s;
    assign rd_valid_o   = rd_valid_q;
    assign rd_ch_o      = out_ch_q;
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign count_o      = count_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_ofm_buffer_mc.sv
// Scoreboard bench for ofm_buffer_mc against a queue/array frame model.
module tb_ofm_buffer_mc;

    localparam int DW    = 16;
    localparam int NCH   = 4;
    localparam int DEPTH = 25;
    localparam int CNT_W = 5;
    localparam int CH_W  = 2;
    localparam int W     = NCH * DW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rd_mode = 1'b0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [W-1:0]     d_in = '0;
    logic [W-1:0]     d_out;
    logic             rd_valid, full, empty, frame_done, err;
    logic [CH_W-1:0]  rd_ch;
    logic [CNT_W-1:0] count;

    always #5 clk = ~clk;

    ofm_buffer_mc #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .IFM_SIZE(9), .KERNEL_SIZE(4), .STRIDE(2), .PAD(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rd_mode_i(rd_mode), .wr_en_i(wr_en), .d_in_i(d_in),
        .rd_en_i(rd_en), .d_out_o(d_out), .rd_valid_o(rd_valid), .rd_ch_o(rd_ch),
        .full_o(full), .empty_o(empty), .count_o(count), .frame_done_o(frame_done), .err_o(err)
    );

    typedef struct {
        logic [W-1:0]    data;
        logic [CH_W-1:0] ch;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Reference model: a FIFO of pixels or a frame array with a drain index
    logic [W-1:0] fifo_m[$];
    logic [W-1:0] frame_m[DEPTH];
    bit           active_m, mode_m, err_m, fd_m;
    int           nwr_m, idx_m, reads_m;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [W-1:0] pix_word(input int p);
        logic [W-1:0] w;
        for (int c = 0; c < NCH; c++) w[c*DW +: DW] = DW'((c << 8) | p);
        return w;
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        fifo_m.delete();
        active_m = 0; mode_m = 0; err_m = 0; fd_m = 0;
        nwr_m = 0; idx_m = 0; reads_m = 0;
    endfunction

    // Monitor: pop and compare whenever the DUT presents read data
    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_read: got d_out=%0h with no read outstanding", d_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (d_out !== mon_e.data || rd_ch !== mon_e.ch) begin
                        fails++;
                        $display("FAIL rd_data: got d_out=%0h rd_ch=%0d expected d_out=%0h rd_ch=%0d",
                                 d_out, rd_ch, mon_e.data, mon_e.ch);
                    end
                end
            end else if (d_out !== '0) begin
                fails++;
                $display("FAIL idle_dout: got %0h expected 0", d_out);
            end
        end
    end

    task automatic step(input bit wr, input logic [W-1:0] d, input bit rd);
        bit           wacc, racc;
        exp_t         e;
        logic [W-1:0] fw;
        int           cnt;
        wr_en = wr; d_in = d; rd_en = rd;
        if (!active_m) begin
            wacc = wr; racc = 0;
        end else if (!mode_m) begin
            racc = rd && fifo_m.size() > 0;
            wacc = wr && (fifo_m.size() < DEPTH || racc);
        end else if (nwr_m < DEPTH) begin
            wacc = wr; racc = 0;
        end else begin
            wacc = 0; racc = rd;
        end
        if ((wr && !wacc) || (rd && !racc)) err_m = 1;
        fd_m = 0;
        if (!active_m && wacc) begin
            active_m = 1;
            mode_m   = rd_mode;
        end
        if (!mode_m) begin
            if (racc) begin
                e.data = fifo_m.pop_front(); e.ch = '0;
                exp_q.push_back(e);
                reads_m++;
            end
            if (wacc) fifo_m.push_back(d);
            if (active_m && reads_m >= DEPTH && fifo_m.size() == 0) begin
                active_m = 0; reads_m = 0; fd_m = 1;
            end
        end else begin
            if (racc) begin
                fw = frame_m[idx_m % DEPTH];
                e.data = '0;
                e.data[DW-1:0] = fw[(idx_m / DEPTH) * DW +: DW];
                e.ch = CH_W'(idx_m / DEPTH);
                exp_q.push_back(e);
                idx_m++;
                if (idx_m == NCH * DEPTH) begin
                    active_m = 0; nwr_m = 0; idx_m = 0; fd_m = 1;
                end
            end
            if (wacc) begin
                frame_m[nwr_m] = d;
                nwr_m++;
            end
        end
        @(posedge clk);
        #1;
        cnt = mode_m ? nwr_m : fifo_m.size();
        chk("count", W'(count), W'(cnt));
        chk("full", W'(full), W'(cnt == DEPTH));
        chk("empty", W'(empty), W'(cnt == 0));
        chk("frame_done", W'(frame_done), W'(fd_m));
`ifdef OFM_BUFFER_ERR_FLAG_EN
        chk("err", W'(err), W'(err_m));
`else
        chk("err", W'(err), W'(0));
`endif
    endtask

    task automatic chk_reset_state();
        chk("rst_count", W'(count), W'(0));
        chk("rst_full", W'(full), W'(0));
        chk("rst_empty", W'(empty), W'(1));
        chk("rst_rd_valid", W'(rd_valid), W'(0));
        chk("rst_d_out", d_out, '0);
        chk("rst_rd_ch", W'(rd_ch), W'(0));
        chk("rst_frame_done", W'(frame_done), W'(0));
        chk("rst_err", W'(err), W'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        do_reset();

        // Read from an empty buffer right after reset
        step(0, '0, 1);
        step(0, '0, 0);
        do_reset();

        // Pixel-parallel: full frame in, full frame out
        rd_mode = 1'b0;
        for (int p = 0; p < DEPTH; p++) step(1, pix_word(p), 0);
        for (int p = 0; p < DEPTH; p++) step(0, '0, 1);
        step(0, '0, 0);

        // Full boundary: lone overflow write dropped, then write+read both accepted
        for (int p = 0; p < DEPTH; p++) step(1, pix_word(p + 32), 0);
        step(1, pix_word(99), 0);
        step(1, pix_word(100), 1);
        for (int p = 0; p < DEPTH; p++) step(0, '0, 1);
        step(0, '0, 0);
        do_reset();

        // Channel-major: reads during fill ignored, write during drain dropped
        rd_mode = 1'b1;
        for (int p = 0; p < DEPTH; p++) step(1, pix_word(p), 1);
        rd_mode = 1'b0;
        for (int i = 0; i < NCH * DEPTH; i++) step(i == 30, pix_word(77), 1);
        step(0, '0, 0);
        step(0, '0, 0);

        // Randomized traffic with random mode per frame
        for (int k = 0; k < 1500; k++) begin
            rd_mode = 1'($urandom_range(0, 1));
            step($urandom_range(0, 9) < 6, {$urandom, $urandom}, $urandom_range(0, 1) == 1);
        end
        for (int k = 0; k < 400 && active_m; k++) begin
            if (!mode_m && fifo_m.size() == 0)   step(1, {$urandom, $urandom}, 0);
            else if (mode_m && nwr_m < DEPTH)    step(1, {$urandom, $urandom}, 0);
            else                                 step(0, '0, 1);
        end
        tests++;
        if (active_m) begin
            fails++;
            $display("FAIL flush_timeout: frame still open after 400 cycles, expected idle");
        end
        step(0, '0, 0);
        do_reset();

        // Asynchronous reset in the middle of a channel-major drain
        rd_mode = 1'b1;
        for (int p = 0; p < DEPTH; p++) step(1, pix_word(p + 5), 0);
        for (int i = 0; i < 40; i++) step(0, '0, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_state();
        do_reset();

        // A fresh pixel-parallel frame after the abort
        rd_mode = 1'b0;
        for (int p = 0; p < DEPTH; p++) step(1, pix_word(p + 60), 0);
        for (int p = 0; p < DEPTH; p++) step(0, '0, 1);
        step(0, '0, 0);
        step(0, '0, 0);
        chk("pending_reads", W'(exp_q.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
